// File: rtl/triangle_wave_analyzer_pkg.sv
// Shared types and default sizing for the triangle wave analyzer.
// One instance per DAC axis imports this package.
package triangle_wave_analyzer_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int PERIOD_W_DEF = 10;
  localparam int STEP_MAX_DEF = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRST   = 2'd1,
    RISING  = 2'd2,
    FALLING = 2'd3
  } tw_state_e;

endpackage

// File: rtl/triangle_period_counter.sv
// Saturating sample counter for period measurement.
// zero beats restart, and restart beats increment.
module triangle_period_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  input  logic         restart,
  input  logic         zero,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  assign sat = (count == CNT_MAX);

  // Counter register with load-zero, load-one and saturating increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
    end else if (clear || zero) begin
      count <= {W{1'b0}};
    end else if (restart) begin
      count <= CNT_ONE;
    end else if (inc && !sat) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/triangle_wave_analyzer.sv
// Receive-side checker for triangle DAC sample streams: slope tracking,
// peak/trough capture, period measurement, slope-step checking and lock.
module triangle_wave_analyzer
  import triangle_wave_analyzer_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int STEP_MAX = STEP_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   sample_in,
  input  logic                sample_valid,
  input  logic                clear,
  output logic                dir_up,
  output logic                peak_pulse,
  output logic                trough_pulse,
  output logic [DATA_W-1:0]   vmax,
  output logic [DATA_W-1:0]   vmin,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                step_err,
  output logic                locked
);

  localparam logic [DATA_W:0] STEP_LIM = (DATA_W + 1)'(STEP_MAX);

  tw_state_e             state_r, state_n;
  logic [DATA_W-1:0]     prev_r, prev_n;
  logic                  have_trough_r, have_trough_n;
  logic                  dir_n, peak_n, trough_n, pv_n, err_n, locked_n;
  logic [DATA_W-1:0]     vmax_n, vmin_n;
  logic [PERIOD_W-1:0]   period_n;
  logic                  cnt_inc, cnt_restart, cnt_zero, cnt_sat;
  logic [PERIOD_W-1:0]   cnt;
  logic [DATA_W:0]       delta;
  logic                  step_viol;

  triangle_period_counter #(.W(PERIOD_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .inc     (cnt_inc),
    .restart (cnt_restart),
    .zero    (cnt_zero),
    .count   (cnt),
    .sat     (cnt_sat)
  );

  // Widened so that 255->0 is seen as a full-scale jump, not a wrap
  assign delta = (sample_in >= prev_r) ? ({1'b0, sample_in} - {1'b0, prev_r})
                                       : ({1'b0, prev_r} - {1'b0, sample_in});
  assign step_viol = (delta > STEP_LIM);

  // Next-state and next-output decode for one accepted sample
  always_comb begin
    state_n       = state_r;
    prev_n        = prev_r;
    have_trough_n = have_trough_r;
    dir_n         = dir_up;
    peak_n        = 1'b0;
    trough_n      = 1'b0;
    pv_n          = 1'b0;
    err_n         = 1'b0;
    locked_n      = locked;
    vmax_n        = vmax;
    vmin_n        = vmin;
    period_n      = period;
    cnt_inc       = 1'b0;
    cnt_restart   = 1'b0;
    cnt_zero      = 1'b0;
    if (sample_valid && !clear) begin
      prev_n  = sample_in;
      cnt_inc = 1'b1;
      if (state_r == IDLE) begin
        state_n = FIRST;
      end else if (step_viol) begin
        err_n         = 1'b1;
        locked_n      = 1'b0;
        have_trough_n = 1'b0;
        cnt_zero      = 1'b1;
        state_n       = FIRST;
      end else begin
        case (state_r)
          FIRST: begin
            if (sample_in > prev_r) begin
              state_n = RISING;
              dir_n   = 1'b1;
            end else if (sample_in < prev_r) begin
              state_n = FALLING;
              dir_n   = 1'b0;
            end else begin
              state_n = FIRST;
            end
          end
          RISING: begin
            if (sample_in < prev_r) begin
              peak_n  = 1'b1;
              vmax_n  = prev_r;
              state_n = FALLING;
              dir_n   = 1'b0;
            end else begin
              state_n = RISING;
            end
          end
          FALLING: begin
            if (sample_in > prev_r) begin
              trough_n      = 1'b1;
              vmin_n        = prev_r;
              state_n       = RISING;
              dir_n         = 1'b1;
              cnt_restart   = 1'b1;
              have_trough_n = 1'b1;
              // A saturated count means the period is unknown, so lock is lost
              if (cnt_sat) begin
                locked_n = 1'b0;
              end else if (have_trough_r) begin
                period_n = cnt;
                pv_n     = 1'b1;
                locked_n = 1'b1;
              end else begin
                locked_n = locked;
              end
            end else begin
              state_n = FALLING;
            end
          end
          default: begin
            state_n = IDLE;
          end
        endcase
      end
    end else begin
      cnt_inc = 1'b0;
    end
  end

  // State and registered outputs; clear acts exactly like rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      prev_r        <= {DATA_W{1'b0}};
      have_trough_r <= 1'b0;
      dir_up        <= 1'b0;
      peak_pulse    <= 1'b0;
      trough_pulse  <= 1'b0;
      vmax          <= {DATA_W{1'b0}};
      vmin          <= {DATA_W{1'b0}};
      period        <= {PERIOD_W{1'b0}};
      period_valid  <= 1'b0;
      step_err      <= 1'b0;
      locked        <= 1'b0;
    end else if (clear) begin
      state_r       <= IDLE;
      prev_r        <= {DATA_W{1'b0}};
      have_trough_r <= 1'b0;
      dir_up        <= 1'b0;
      peak_pulse    <= 1'b0;
      trough_pulse  <= 1'b0;
      vmax          <= {DATA_W{1'b0}};
      vmin          <= {DATA_W{1'b0}};
      period        <= {PERIOD_W{1'b0}};
      period_valid  <= 1'b0;
      step_err      <= 1'b0;
      locked        <= 1'b0;
    end else begin
      state_r       <= state_n;
      prev_r        <= prev_n;
      have_trough_r <= have_trough_n;
      dir_up        <= dir_n;
      peak_pulse    <= peak_n;
      trough_pulse  <= trough_n;
      vmax          <= vmax_n;
      vmin          <= vmin_n;
      period        <= period_n;
      period_valid  <= pv_n;
      step_err      <= err_n;
      locked        <= locked_n;
    end
  end

endmodule

// File: tb/tb_triangle_wave_analyzer.sv
// Scoreboard bench: a behavioural model predicts outputs for each driven
// cycle; a monitor compares them one clock later.
module tb_triangle_wave_analyzer;

  localparam int STEP = 1;
  localparam int CMAX = 1023;

  typedef struct packed {
    logic       dir;
    logic       peak;
    logic       trough;
    logic [7:0] vmax;
    logic [7:0] vmin;
    logic [9:0] period;
    logic       pv;
    logic       se;
    logic       locked;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = 8'd0;
  logic       sample_valid = 1'b0;
  logic       clear = 1'b0;
  logic       dir_up, peak_pulse, trough_pulse, period_valid, step_err, locked;
  logic [7:0] vmax, vmin;
  logic [9:0] period;

  int total = 0;
  int bad = 0;
  exp_t q[$];

  // model state: slope is 0 unknown, +1 rising, -1 falling
  bit   m_started;
  int   m_slope, m_prev, m_cnt;
  bit   m_ht;
  exp_t m_out;

  // stream generator
  int g_val;
  bit g_up;

  triangle_wave_analyzer dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .clear(clear), .dir_up(dir_up), .peak_pulse(peak_pulse),
    .trough_pulse(trough_pulse), .vmax(vmax), .vmin(vmin), .period(period),
    .period_valid(period_valid), .step_err(step_err), .locked(locked)
  );

  always #5 clk = ~clk;

  function automatic exp_t dut_out();
    exp_t o;
    o = '{dir_up, peak_pulse, trough_pulse, vmax, vmin, period,
          period_valid, step_err, locked};
    return o;
  endfunction

  task automatic model_reset();
    m_started = 1'b0; m_slope = 0; m_prev = 0; m_cnt = 0; m_ht = 1'b0;
    m_out = '0;
  endtask

  task automatic model_strobes_off();
    m_out.peak = 1'b0; m_out.trough = 1'b0; m_out.pv = 1'b0; m_out.se = 1'b0;
  endtask

  task automatic model_sample(input int s);
    int d, old;
    model_strobes_off();
    if (!m_started) begin
      m_started = 1'b1;
      m_prev = s;
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      return;
    end
    d = s - m_prev;
    if (d > STEP || -d > STEP) begin
      m_out.se = 1'b1; m_out.locked = 1'b0;
      m_ht = 1'b0; m_cnt = 0; m_slope = 0; m_prev = s;
      return;
    end
    old = m_cnt;
    m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    if (m_slope == 0) begin
      if (d > 0) begin m_slope = 1; m_out.dir = 1'b1; end
      else if (d < 0) begin m_slope = -1; m_out.dir = 1'b0; end
    end else if (m_slope == 1 && d < 0) begin
      m_out.peak = 1'b1; m_out.vmax = 8'(m_prev); m_slope = -1; m_out.dir = 1'b0;
    end else if (m_slope == -1 && d > 0) begin
      m_out.trough = 1'b1; m_out.vmin = 8'(m_prev); m_slope = 1; m_out.dir = 1'b1;
      if (old == CMAX) m_out.locked = 1'b0;
      else if (m_ht) begin
        m_out.period = 10'(old); m_out.pv = 1'b1; m_out.locked = 1'b1;
      end
      m_ht = 1'b1;
      m_cnt = 1;
    end
    m_prev = s;
  endtask

  task automatic cycle(input bit v, input int s, input bit c);
    @(posedge clk);
    #1;
    sample_valid = v; sample_in = 8'(s); clear = c;
    if (c) model_reset();
    else if (v) model_sample(s);
    else model_strobes_off();
    q.push_back(m_out);
  endtask

  // vmode: 0 continuous, 1 alternate valid/idle, 2 random idle gaps
  task automatic emit(input int s, input int vmode);
    if (vmode == 2) repeat ($urandom_range(0, 2)) cycle(1'b0, 0, 1'b0);
    cycle(1'b1, s, 1'b0);
    if (vmode == 1) cycle(1'b0, 0, 1'b0);
  endtask

  task automatic tri_run(input int n, input int vmode);
    repeat (n) begin
      emit(g_val, vmode);
      if (g_up) begin
        if (g_val == 255) begin g_up = 1'b0; g_val = 254; end
        else g_val++;
      end else begin
        if (g_val == 0) begin g_up = 1'b1; g_val = 1; end
        else g_val--;
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic flush();
    cycle(1'b0, 0, 1'b0);
    for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
    total++;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL flush_timeout got=%0d exp=0", q.size());
      q.delete();
    end
  endtask

  task automatic restart_stream(input int v, input bit up);
    cycle(1'b0, 0, 1'b1);
    g_val = v; g_up = up;
  endtask

  // monitor: an entry queued before an edge describes outputs after that edge
  initial begin
    bit   pend;
    exp_t e, g;
    forever begin
      @(posedge clk);
      pend = (q.size() > 0);
      @(negedge clk);
      if (pend) begin
        e = q.pop_front();
        g = dut_out();
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got=%h exp=%h", $time, g, e);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'(dut_out()), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // full ramps from 0
    g_val = 0; g_up = 1'b1;
    tri_run(1022, 0);
    flush();
    chk("ramp_period", period, 510);
    chk("ramp_locked", locked, 1);
    chk("ramp_vmax", vmax, 255);
    chk("ramp_vmin", vmin, 0);

    // async reset while falling, with a valid sample presented
    restart_stream(0, 1'b1);
    tri_run(300, 0);
    flush();
    @(negedge clk);
    sample_valid = 1'b1; sample_in = 8'd77;
    #2 rst_n = 1'b0;
    #1 chk("async_reset", int'(dut_out()), 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; sample_valid = 1'b0;
    model_reset();
    #1 chk("reset_held", int'(dut_out()), 0);

    // phase-shifted start at 128
    g_val = 128; g_up = 1'b1;
    tri_run(894, 0);
    flush();
    chk("phase_period", period, 510);
    chk("phase_vmax", vmax, 255);

    // slope-step violation mid-ramp, then relock
    restart_stream(0, 1'b1);
    tri_run(101, 0);
    emit(103, 0);
    g_val = 104;
    flush();
    chk("step_unlocked", locked, 0);
    tri_run(918, 0);
    flush();
    chk("relock", locked, 1);
    chk("relock_period", period, 510);

    // valid toggling every cycle
    restart_stream(0, 1'b1);
    tri_run(1022, 1);
    flush();
    chk("toggle_period", period, 510);

    // hold at 200 while falling adds 20 counts
    restart_stream(0, 1'b1);
    tri_run(512, 0);
    tri_run(309, 0);
    repeat (20) emit(200, 0);
    tri_run(201, 0);
    flush();
    chk("hold_period", period, 530);

    // saturated counter at a trough drops lock and skips period
    restart_stream(0, 1'b1);
    tri_run(513, 0);
    repeat (1100) emit(2, 0);
    tri_run(509, 0);
    flush();
    chk("sat_locked", locked, 0);
    chk("sat_period", period, 0);
    tri_run(510, 0);
    flush();
    chk("post_sat_period", period, 510);

    // clear together with a valid sample
    cycle(1'b1, 50, 1'b1);
    flush();
    chk("clear_outputs", int'(dut_out()), 0);
    emit(60, 0); emit(61, 0); emit(62, 0);
    flush();

    // randomized streams with gaps, jumps and clears
    for (int seg = 0; seg < 3; seg++) begin
      g_val = $urandom_range(0, 255); g_up = 1'($urandom_range(0, 1));
      repeat ($urandom_range(300, 700)) begin
        if ($urandom_range(0, 199) == 0) begin
          g_val = $urandom_range(0, 255);
        end else if ($urandom_range(0, 399) == 0) begin
          cycle(1'b1, $urandom_range(0, 255), 1'b1);
        end
        tri_run(1, 2);
      end
      flush();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
